// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the counter width function.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = ai - bi - bin.
// Purely combinational; bout is the borrow into the next bit.
module full_subtractor (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = ai ^ bi ^ bin;
  assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit unsigned subtractor, LSB first, start/busy/done.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_a_q, sreg_b_q;
  logic [WIDTH-1:0] res_q, diff_q;
  logic             brw_q, bout_q;
  logic [CW-1:0]    cnt_q;
  logic             d_bit, b_next;
  logic             last;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;
`endif

  full_subtractor u_fs (
    .ai   (sreg_a_q[0]),
    .bi   (sreg_b_q[0]),
    .bin  (brw_q),
    .d    (d_bit),
    .bout (b_next)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_a_q <= '0;
      sreg_b_q <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      brw_q    <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == IDLE && start) begin
      sreg_a_q <= a;
      sreg_b_q <= b;
      res_q    <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == SHIFT) begin
      sreg_a_q <= sreg_a_q >> 1;
      sreg_b_q <= sreg_b_q >> 1;
      res_q    <= {d_bit, res_q[WIDTH-1:1]};
      brw_q    <= b_next;
      cnt_q    <= cnt_q + CW'(1);
      // publish on the last bit so outputs move only into DONE
      if (last) begin
        diff_q <= {d_bit, res_q[WIDTH-1:1]};
        bout_q <= b_next;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE && start) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == SHIFT && last) begin
      ovf_q <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Expected results are queued at start and compared at done.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic [W-1:0] diff;
  logic         borrow_out, busy, done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];
  logic [W:0] last_exp;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y};
    return r;
  endfunction

  // called at a negedge while idle; returns at the negedge after acceptance
  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bsy);
    lat = 1;
    bsy = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bsy++;
      if (done) return;
      @(negedge clk);
      lat++;
    end
    lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({diff, borrow_out, busy, done} !== {8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset: diff=%h bo=%b busy=%b done=%b want 00 0 0 0",
               diff, borrow_out, busy, done);
    end
    last_exp = '0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [W-1:0] av[4];
    logic [W-1:0] bv[4];
    logic [W:0]   e;
    int lat, bsy;
    av = '{8'd100, 8'd5, 8'hFF, 8'h00};
    bv = '{8'd37, 8'd9, 8'hFF, 8'h01};
    for (int i = 0; i < 4; i++) begin
      drive_start(av[i], bv[i]);
      wait_done(lat, bsy);
      checks++;
      if (lat != W + 1) begin
        errors++;
        $display("FAIL basic%0d latency: got %0d want %0d", i, lat, W + 1);
      end
      checks++;
      if (bsy != W + 1) begin
        errors++;
        $display("FAIL basic%0d busy cycles: got %0d want %0d", i, bsy, W + 1);
      end
      e = exp_q.pop_front();
      last_exp = e;
      checks++;
      if ({borrow_out, diff} !== e) begin
        errors++;
        $display("FAIL basic%0d result: got bo=%b diff=%h want bo=%b diff=%h",
                 i, borrow_out, diff, e[W], e[W-1:0]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {borrow_out, diff} !== e) begin
        errors++;
        $display("FAIL basic%0d post: done=%b busy=%b diff=%h want 0 0 %h",
                 i, done, busy, diff, e[W-1:0]);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [W:0] e;
    int lat, bsy, extra;
    drive_start(8'd20, 8'd3);
    @(negedge clk);
    a = 8'd1;
    b = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bsy);
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL ignore timeout: done=%b want 1", done);
    end
    e = exp_q.pop_front();
    last_exp = e;
    checks++;
    if ({borrow_out, diff} !== e) begin
      errors++;
      $display("FAIL ignore result: got diff=%h bo=%b want diff=%h bo=%b",
               diff, borrow_out, e[W-1:0], e[W]);
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore extra done: got %0d pulses want 0", extra);
    end
  endtask

  task automatic test_reset_abort;
    logic [W:0] e;
    int lat, bsy, seen;
    drive_start(8'd50, 8'd7);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, borrow_out, diff} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL abort state: busy=%b done=%b bo=%b diff=%h want 0 0 0 00",
               busy, done, borrow_out, diff);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort done: got %0d pulses want 0", seen);
    end
    drive_start(8'd10, 8'd10);
    wait_done(lat, bsy);
    e = exp_q.pop_front();
    last_exp = e;
    checks++;
    if (lat < 0 || {borrow_out, diff} !== e) begin
      errors++;
      $display("FAIL abort restart: lat=%0d diff=%h bo=%b want diff=%h bo=%b",
               lat, diff, borrow_out, e[W-1:0], e[W]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] av[3];
    logic [W-1:0] bv[3];
    logic [W:0]   e;
    int t, t_prev;
    bit found, hold_ok;
    av = '{8'd30, 8'd200, 8'd7};
    bv = '{8'd4, 8'd100, 8'd9};
    a = av[0];
    b = bv[0];
    start = 1'b1;
    exp_q.push_back(model(av[0], bv[0]));
    t = 0;
    t_prev = 0;
    hold_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        t++;
        if (done) begin
          found = 1'b1;
          break;
        end
        if ({borrow_out, diff} !== last_exp) hold_ok = 1'b0;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL b2b%0d timeout: done=%b want 1", i, done);
      end
      if (i > 0) begin
        checks++;
        if (t - t_prev != W + 2) begin
          errors++;
          $display("FAIL b2b%0d period: got %0d want %0d", i, t - t_prev, W + 2);
        end
      end
      e = exp_q.pop_front();
      checks++;
      if ({borrow_out, diff} !== e) begin
        errors++;
        $display("FAIL b2b%0d result: got diff=%h bo=%b want diff=%h bo=%b",
                 i, diff, borrow_out, e[W-1:0], e[W]);
      end
      last_exp = e;
      t_prev = t;
      if (i < 2) begin
        a = av[i+1];
        b = bv[i+1];
        exp_q.push_back(model(av[i+1], bv[i+1]));
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL b2b hold: diff=%h changed between dones want held", diff);
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  task automatic test_ovf;
    logic [W-1:0] av[2];
    logic [W-1:0] bv[2];
    logic [W:0]   e;
    logic         eo;
    int lat, bsy, r;
    av = '{8'h80, 8'h10};
    bv = '{8'h01, 8'h01};
    for (int i = 0; i < 2; i++) begin
      r = int'($signed(av[i])) - int'($signed(bv[i]));
      eo = (r > 127 || r < -128);
      drive_start(av[i], bv[i]);
      wait_done(lat, bsy);
      e = exp_q.pop_front();
      checks++;
      if (lat < 0 || {borrow_out, diff} !== e || ovf !== eo) begin
        errors++;
        $display("FAIL ovf%0d: diff=%h bo=%b ovf=%b want diff=%h bo=%b ovf=%b",
                 i, diff, borrow_out, ovf, e[W-1:0], e[W], eo);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    test_ovf();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
